// File: rtl/serial_pattern_ctrl.sv
// serial_pattern_ctrl
//   Sequencer for the serial "1011" pattern detector. Captures a parallel word
//   on an accepted start and presents it to the detector one bit per clk_2
//   cycle, MSB first. Keeps the detector cleared between runs and counts the
//   detector hits produced by the word (saturating).
//
// Ports
//   clk_2      in   1       system clock, all state on posedge
//   reset_n    in   1       asynchronous active-low reset
//   start      in   1       run request, only honoured in IDLE
//   word_in    in   NBITS   word to serialise, captured on accepted start
//   flush      in   1       abort current run, beats everything but reset_n
//   det_hit    in   1       detector out_bit (registered in the detector)
//   det_bit    out  1       serial bit to detector in_bit
//   det_clr    out  1       synchronous clear to the detector
//   busy       out  1       high in SHIFT or DRAIN
//   done       out  1       one-cycle pulse on a run completed without flush
//   hit_count  out  NCOUNT  hits counted in the last or current run

module serial_pattern_ctrl #(
    parameter int unsigned NBITS  = 8,
    parameter int unsigned NCOUNT = 4
) (
    input  logic              clk_2,
    input  logic              reset_n,
    input  logic              start,
    input  logic [NBITS-1:0]  word_in,
    input  logic              flush,
    input  logic              det_hit,
    output logic              det_bit,
    output logic              det_clr,
    output logic              busy,
    output logic              done,
    output logic [NCOUNT-1:0] hit_count
);

    localparam int unsigned CW = $clog2(NBITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);
    localparam logic [NCOUNT-1:0] HIT_MAX = '1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDrain,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [NBITS-1:0]  shreg_q, shreg_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [NCOUNT-1:0] hit_cnt_q, hit_cnt_d;
    logic [NCOUNT-1:0] hit_cnt_inc;

    // Saturating increment on a detector hit.
    always_comb begin
        hit_cnt_inc = hit_cnt_q;
        if (det_hit && (hit_cnt_q != HIT_MAX)) begin
            hit_cnt_inc = hit_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        hit_cnt_d = hit_cnt_q;
        det_bit   = 1'b0;
        det_clr   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                det_clr = 1'b1;
                if (start && !flush) begin
                    shreg_d   = word_in;
                    bit_cnt_d = '0;
                    hit_cnt_d = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                busy      = 1'b1;
                det_bit   = shreg_q[NBITS-1];
                shreg_d   = shreg_q << 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                hit_cnt_d = hit_cnt_inc;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = StDrain;
                end
            end
            // One extra cycle so the hit caused by the last bit is counted.
            StDrain: begin
                busy      = 1'b1;
                hit_cnt_d = hit_cnt_inc;
                state_d   = StDone;
            end
            StDone: begin
                done    = 1'b1;
                det_clr = 1'b1;
                state_d = StIdle;
            end
        endcase

        // Abort: freeze the datapath, keep the partial hit count, drop to IDLE.
        if (flush && (state_q != StIdle)) begin
            state_d   = StIdle;
            shreg_d   = shreg_q;
            bit_cnt_d = bit_cnt_q;
            hit_cnt_d = hit_cnt_q;
        end
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            hit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_count = hit_cnt_q;

endmodule

// File: tb/tb_serial_pattern_ctrl.sv
module tb_serial_pattern_ctrl;

    localparam int unsigned NBITS  = 8;
    localparam int unsigned NCOUNT = 4;

    logic              clk_2   = 1'b0;
    logic              reset_n = 1'b0;
    logic              start   = 1'b0;
    logic              flush   = 1'b0;
    logic [NBITS-1:0]  word_in = '0;
    logic              det_hit;
    logic              det_bit, det_clr, busy, done;
    logic [NCOUNT-1:0] hit_count;

    // Second instance with a 2-bit counter and a stuck-at-1 hit input.
    logic              start_s   = 1'b0;
    logic              flush_s   = 1'b0;
    logic [NBITS-1:0]  word_s    = 8'hFF;
    logic              det_hit_s = 1'b1;
    logic              det_bit_s, det_clr_s, busy_s, done_s;
    logic [1:0]        hit_count_s;

    serial_pattern_ctrl #(.NBITS(NBITS), .NCOUNT(NCOUNT)) dut (
        .clk_2     (clk_2),
        .reset_n   (reset_n),
        .start     (start),
        .word_in   (word_in),
        .flush     (flush),
        .det_hit   (det_hit),
        .det_bit   (det_bit),
        .det_clr   (det_clr),
        .busy      (busy),
        .done      (done),
        .hit_count (hit_count)
    );

    serial_pattern_ctrl #(.NBITS(NBITS), .NCOUNT(2)) dut_sat (
        .clk_2     (clk_2),
        .reset_n   (reset_n),
        .start     (start_s),
        .word_in   (word_s),
        .flush     (flush_s),
        .det_hit   (det_hit_s),
        .det_bit   (det_bit_s),
        .det_clr   (det_clr_s),
        .busy      (busy_s),
        .done      (done_s),
        .hit_count (hit_count_s)
    );

    always #5 clk_2 = ~clk_2;

    int cyc = 0;
    always @(posedge clk_2) cyc <= cyc + 1;

    // Overlapping "1011" detector with registered output and synchronous clear.
    logic [1:0] d_st  = 2'd0;
    logic       d_out = 1'b0;
    assign det_hit = d_out;
    always @(posedge clk_2) begin
        if (det_clr) begin
            d_st  <= 2'd0;
            d_out <= 1'b0;
        end else begin
            d_out <= (d_st == 2'd3) && det_bit;
            case (d_st)
                2'd0:    d_st <= det_bit ? 2'd1 : 2'd0;
                2'd1:    d_st <= det_bit ? 2'd1 : 2'd2;
                2'd2:    d_st <= det_bit ? 2'd3 : 2'd0;
                default: d_st <= det_bit ? 2'd1 : 2'd2;
            endcase
        end
    end

    typedef struct {
        int done_cyc;
        int hits;
    } run_t;

    run_t runs[$];
    bit   bits[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int count_1011(input logic [7:0] w, input int max);
        int n = 0;
        for (int i = 7; i >= 3; i--) begin
            if (w[i -: 4] == 4'b1011) n++;
        end
        return (n > max) ? max : n;
    endfunction

    // Expected serial bits: NBITS data bits MSB first, then a 0 in DRAIN.
    task automatic push_run(input logic [7:0] w, input int done_at);
        run_t r;
        for (int i = NBITS - 1; i >= 0; i--) bits.push_back(w[i]);
        bits.push_back(1'b0);
        r.done_cyc = done_at;
        r.hits     = count_1011(w, (1 << NCOUNT) - 1);
        runs.push_back(r);
    endtask

    // Called on a negedge; returns on the negedge of the first SHIFT cycle.
    task automatic issue(input logic [7:0] w);
        word_in = w;
        start   = 1'b1;
        push_run(w, cyc + NBITS + 2);
        @(negedge clk_2);
        start = 1'b0;
    endtask

    task automatic settle();
        repeat (NBITS + 4) @(negedge clk_2);
        check("runs_pending", runs.size(), 0);
        check("bits_pending", bits.size(), 0);
    endtask

    // Scoreboard consumer.
    always @(negedge clk_2) begin
        bit   b;
        run_t r;
        if (reset_n) begin
            if (busy) begin
                if (bits.size() == 0) begin
                    check("busy_unexp", busy, 0);
                end else begin
                    b = bits.pop_front();
                    check("det_bit", det_bit, b);
                    check("det_clr_run", det_clr, 0);
                end
            end
            if (done) begin
                if (runs.size() == 0) begin
                    check("done_unexp", done, 0);
                end else begin
                    r = runs.pop_front();
                    check("done_cyc", cyc, r.done_cyc);
                    check("hit_count", hit_count, r.hits);
                    check("det_clr_done", det_clr, 1);
                end
            end
        end
    end

    initial begin
        // Reset, released mid-clock on a negedge.
        repeat (2) @(negedge clk_2);
        check("rst_det_clr", det_clr, 1);
        check("rst_det_bit", det_bit, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hit_count", hit_count, 0);
        @(negedge clk_2);
        reset_n = 1'b1;
        @(negedge clk_2);
        check("idle_det_clr", det_clr, 1);
        check("idle_busy", busy, 0);
        check("idle_hit_count", hit_count, 0);

        // Basic runs with the real detector.
        issue(8'hB0);
        settle();
        issue(8'hBB);
        settle();
        check("hit_hold", hit_count, 2);
        issue(8'h00);
        @(negedge clk_2);
        word_in = 8'hFF;
        start   = 1'b1;   // ignored while busy
        @(negedge clk_2);
        start = 1'b0;
        settle();
        issue(8'hFF);
        settle();

        // Flush on the 4th SHIFT cycle.
        issue(8'hB0);
        repeat (3) @(negedge clk_2);
        flush = 1'b1;
        runs.delete();
        @(negedge clk_2);
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_det_clr", det_clr, 1);
        check("flush_done", done, 0);
        check("flush_hits", hit_count, 0);
        repeat (NBITS + 4) @(negedge clk_2);
        bits.delete();

        // Flush in IDLE blocks start.
        flush   = 1'b1;
        start   = 1'b1;
        word_in = 8'hBB;
        @(negedge clk_2);
        flush = 1'b0;
        start = 1'b0;
        check("flush_blocks_start", busy, 0);
        @(negedge clk_2);
        issue(8'hBB);
        settle();

        // start held high: back-to-back runs, one IDLE cycle apart.
        word_in = 8'hBB;
        start   = 1'b1;
        push_run(8'hBB, cyc + NBITS + 2);
        push_run(8'hBB, cyc + 2 * NBITS + 5);
        repeat (12) @(negedge clk_2);
        start = 1'b0;
        settle();

        // Reset asserted mid-run.
        issue(8'hBB);
        repeat (3) @(negedge clk_2);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_hits", hit_count, 0);
        check("midrst_det_clr", det_clr, 1);
        check("midrst_done", done, 0);
        runs.delete();
        bits.delete();
        repeat (2) @(negedge clk_2);
        reset_n = 1'b1;
        repeat (NBITS + 4) @(negedge clk_2);
        check("midrst_stays_idle", busy, 0);

        // Saturation with NCOUNT=2 and det_hit stuck high.
        start_s = 1'b1;
        @(negedge clk_2);
        start_s = 1'b0;
        repeat (NBITS + 1) @(negedge clk_2);
        check("sat_done", done_s, 1);
        check("sat_hits", hit_count_s, 3);
        @(negedge clk_2);
        check("sat_done_pulse", done_s, 0);
        check("sat_busy", busy_s, 0);
        check("sat_hold", hit_count_s, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
